// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - weight encoding, FSM states and saturating add shared by the ternary layer sequencer
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  localparam int ACC_W_DEF = 7;

  // Working width of sat_add; accumulators up to this width are supported.
  localparam int SAT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_OUT,
    S_DONE
  } state_t;

  // Signed add of two SAT_W-bit operands, clamped to the range of a w-bit signed value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi = (SAT_W+1)'((1 << (w - 1)) - 1);
    lo = ~hi;
    if (s > hi) begin
      return hi[SAT_W-1:0];
    end else if (s < lo) begin
      return lo[SAT_W-1:0];
    end
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/ternary_sat_accum.sv
// rtl/ternary_sat_accum.sv - registered saturating accumulator of ternary weight x activation products
module ternary_sat_accum
  import ternary_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [1:0]              x,
  input  logic [1:0]              w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [2:0]       prod;

  // Decode the ternary weight into a signed 3-bit product; code 10 behaves as zero.
  always_comb begin
    prod = 3'sd0;
    case (w)
      W_POS:   prod = $signed({1'b0, x});
      W_NEG:   prod = -$signed({1'b0, x});
      default: prod = 3'sd0;
    endcase
  end

  // Clear wins over accumulate; the two are never requested together by the sequencer.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(prod), ACC_W));
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ternary_layer_sequencer.sv
// rtl/ternary_layer_sequencer.sv - ternary FC layer sequencer; TERNARY_SEQ_RELU_EN clamps negative results to zero
module ternary_layer_sequencer
  import ternary_pkg::*;
#(
  parameter  int N_IN  = 14,
  parameter  int N_OUT = 8,
  parameter  int ACC_W = ACC_W_DEF,
  parameter  int WA_W  = 7,
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*N_IN-1:0] x_vec,
  output logic              busy,
  output logic              w_rd_en,
  output logic [WA_W-1:0]   w_addr,
  input  logic [1:0]        w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [NW-1:0]     out_idx,
  output logic              layer_done
);

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

  state_t              state_q, state_d;
  logic [2*N_IN-1:0]   x_q, x_d;
  logic [NW-1:0]       n_q, n_d;
  logic [IW-1:0]       i_q, i_d;
  logic [IW-1:0]       i_d1_q, i_d1_d;
  logic                rd_d1_q, rd_d1_d;
  logic                w_rd_en_q, w_rd_en_d;
  logic [WA_W-1:0]     w_addr_q, w_addr_d;
  logic                out_valid_q, out_valid_d;
  logic                layer_done_q, layer_done_d;
  logic                busy_q, busy_d;
  logic                acc_clr;
  logic [1:0]          x_sel;
  logic signed [ACC_W-1:0] acc;

  // Activation paired with the weight returning this cycle (issued one cycle earlier).
  assign x_sel = x_q[{i_d1_q, 1'b0} +: 2];

  ternary_sat_accum #(
    .ACC_W(ACC_W)
  ) u_accum (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (rd_d1_q),
    .x   (x_sel),
    .w   (w_data),
    .acc (acc)
  );

  // Next-state logic: read issue, neuron stepping and result handshake.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    n_d          = n_q;
    i_d          = i_q;
    i_d1_d       = i_q;
    rd_d1_d      = w_rd_en_q;
    w_rd_en_d    = 1'b0;
    w_addr_d     = w_addr_q;
    out_valid_d  = out_valid_q;
    layer_done_d = 1'b0;
    acc_clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x_vec;
          n_d       = '0;
          i_d       = '0;
          w_addr_d  = '0;
          w_rd_en_d = 1'b1;
          acc_clr   = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_q == I_LAST) begin
          state_d = S_LAST;
        end else begin
          i_d       = i_q + 1'b1;
          w_addr_d  = w_addr_q + 1'b1;
          w_rd_en_d = 1'b1;
        end
      end
      S_LAST: begin
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (n_q != N_LAST) begin
            n_d       = n_q + 1'b1;
            i_d       = '0;
            w_addr_d  = w_addr_q + 1'b1;
            w_rd_en_d = 1'b1;
            acc_clr   = 1'b1;
            state_d   = S_FETCH;
          end else begin
            layer_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; rst aborts any layer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      i_d1_q       <= '0;
      rd_d1_q      <= 1'b0;
      w_rd_en_q    <= 1'b0;
      w_addr_q     <= '0;
      out_valid_q  <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      n_q          <= n_d;
      i_q          <= i_d;
      i_d1_q       <= i_d1_d;
      rd_d1_q      <= rd_d1_d;
      w_rd_en_q    <= w_rd_en_d;
      w_addr_q     <= w_addr_d;
      out_valid_q  <= out_valid_d;
      layer_done_q <= layer_done_d;
      busy_q       <= busy_d;
    end
  end

  // Present the finished accumulator only while a result is offered.
  always_comb begin
    out_data = '0;
`ifdef TERNARY_SEQ_RELU_EN
    if (out_valid_q && !acc[ACC_W-1]) begin
      out_data = acc;
    end
`else
    if (out_valid_q) begin
      out_data = acc;
    end
`endif
  end

  assign busy       = busy_q;
  assign w_rd_en    = w_rd_en_q;
  assign w_addr     = w_addr_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = n_q;
  assign layer_done = layer_done_q;

endmodule
